// File: rtl/ml_pkg.sv
// rtl/ml_pkg.sv - shared opcodes, decoder states and word type for the ML command decoder
//
// Contents:
//   CMD_NOP / CMD_WRITE / CMD_RUN : command opcodes
//   ml_word_t                     : 16-bit memory word
//   ml_state_e                    : byte-parser state enumeration
package ml_pkg;

    localparam logic [7:0] CMD_NOP   = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h21;
    localparam logic [7:0] CMD_RUN   = 8'h23;

    typedef logic [15:0] ml_word_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_OPC,
        ST_WA_HI,
        ST_WA_LO,
        ST_WD_HI,
        ST_WD_LO,
        ST_RA_HI,
        ST_RA_LO,
        ST_SKIP
    } ml_state_e;

endpackage

// File: rtl/ml_wr_slot.sv
// rtl/ml_wr_slot.sv - single-entry valid/ready holding register with overflow detect
//
// Ports:
//   i_clock, i_resetn : clock, asynchronous active-low reset
//   i_push            : a new word is offered this cycle
//   i_addr, i_data    : address/data of the offered word
//   i_ready           : downstream accepts the held word this cycle
//   o_valid           : a word is held
//   o_addr, o_data    : held word, stable until accepted
//   o_accept          : the offered word was taken into the slot
//   o_ovf             : the offered word was dropped (slot full and not draining)
module ml_wr_slot
    import ml_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          i_clock,
    input  logic          i_resetn,
    input  logic          i_push,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic [15:0]   o_data,
    output logic          o_accept,
    output logic          o_ovf
);

    logic          r_valid;
    logic [AW-1:0] r_addr;
    ml_word_t      r_data;

    // A word draining this cycle frees the slot for a word arriving in the same cycle.
    assign o_accept = i_push && (!r_valid || i_ready);
    assign o_ovf    = i_push && r_valid && !i_ready;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (o_accept) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule

// File: rtl/ml_cmd_decoder.sv
// rtl/ml_cmd_decoder.sv - QSPI byte-stream command decoder producing memory writes and run requests
//
// Optional feature: define MARLANN_ERRCNT_EN to add the err_count output
// (saturating count of error events, cleared with err by a NOP).
//
// Ports:
//   clock, resetn              : clock, asynchronous active-low reset
//   frame                      : chip-select active level, already synchronised
//   din_valid, din_data        : received byte strobe and value
//   mem_wr_valid/ready         : memory write handshake
//   mem_wr_addr, mem_wr_data   : word address and data of the pending write
//   run_start                  : one-cycle compute start pulse
//   run_addr                   : start address of the last accepted RUN
//   run_busy                   : compute engine busy
//   rdy                        : host may send the next frame
//   err                        : sticky error flag
//   err_count                  : saturating error event count (MARLANN_ERRCNT_EN only)
module ml_cmd_decoder
    import ml_pkg::*;
#(
    parameter int         MEM_AW    = 16,
    parameter logic [7:0] CMD_WRITE = ml_pkg::CMD_WRITE,
    parameter logic [7:0] CMD_RUN   = ml_pkg::CMD_RUN
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              frame,
    input  logic              din_valid,
    input  logic [7:0]        din_data,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [MEM_AW-1:0] mem_wr_addr,
    output logic [15:0]       mem_wr_data,
    output logic              run_start,
    output logic [MEM_AW-1:0] run_addr,
    input  logic              run_busy,
    output logic              rdy,
    output logic              err
`ifdef MARLANN_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    ml_state_e         r_state;
    logic              r_frame_d;
    logic [7:0]        r_hi;
    logic [MEM_AW-1:0] r_addr;
    logic [MEM_AW-1:0] r_run_addr;
    logic              r_run_start;
    logic              r_err;

    logic              w_byte;
    logic              w_rise;
    logic              w_fall;
    ml_word_t          w_word;
    logic              w_push;
    logic              w_accept;
    logic              w_ovf;
    logic              w_bad_opc;
    logic              w_trunc;
    logic              w_run_rej;
    logic              w_set_err;
    logic              w_clr_err;
    logic              w_slot_valid;
    logic [MEM_AW-1:0] w_slot_addr;
    ml_word_t          w_slot_data;

    assign w_byte = din_valid && frame;
    assign w_rise = frame && !r_frame_d;
    // The falling edge is seen one cycle after the last byte sampled with frame high,
    // so any byte at the end of the frame has already moved the state on.
    assign w_fall = !frame && r_frame_d;
    assign w_word = {r_hi, din_data};
    assign w_push = w_byte && (r_state == ST_WD_LO);

    assign w_bad_opc = w_byte && (r_state == ST_OPC) && (din_data != CMD_NOP) &&
                       (din_data != CMD_WRITE) && (din_data != CMD_RUN);
    assign w_trunc   = w_fall && (r_state inside {ST_WA_HI, ST_WA_LO, ST_WD_LO,
                                                  ST_RA_HI, ST_RA_LO});
    assign w_run_rej = w_byte && (r_state == ST_RA_LO) && run_busy;
    assign w_set_err = w_bad_opc || w_trunc || w_run_rej || w_ovf;
    assign w_clr_err = w_byte && (r_state == ST_OPC) && (din_data == CMD_NOP);

    ml_wr_slot #(
        .AW(MEM_AW)
    ) u_wr_slot (
        .i_clock  (clock),
        .i_resetn (resetn),
        .i_push   (w_push),
        .i_addr   (r_addr),
        .i_data   (w_word),
        .i_ready  (mem_wr_ready),
        .o_valid  (w_slot_valid),
        .o_addr   (w_slot_addr),
        .o_data   (w_slot_data),
        .o_accept (w_accept),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_frame_d   <= 1'b0;
            r_hi        <= '0;
            r_addr      <= '0;
            r_run_addr  <= '0;
            r_run_start <= 1'b0;
        end else begin
            r_frame_d   <= frame;
            r_run_start <= 1'b0;
            if (w_fall) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) r_state <= ST_OPC;
                    end
                    ST_OPC: begin
                        if (w_byte) begin
                            if (din_data == CMD_WRITE)    r_state <= ST_WA_HI;
                            else if (din_data == CMD_RUN) r_state <= ST_RA_HI;
                            else                          r_state <= ST_SKIP;
                        end
                    end
                    ST_WA_HI: begin
                        if (w_byte) begin
                            r_hi    <= din_data;
                            r_state <= ST_WA_LO;
                        end
                    end
                    ST_WA_LO: begin
                        if (w_byte) begin
                            r_addr  <= w_word[MEM_AW-1:0];
                            r_state <= ST_WD_HI;
                        end
                    end
                    ST_WD_HI: begin
                        if (w_byte) begin
                            r_hi    <= din_data;
                            r_state <= ST_WD_LO;
                        end
                    end
                    ST_WD_LO: begin
                        if (w_byte) begin
                            // A dropped word does not consume an address.
                            if (w_accept) r_addr <= r_addr + MEM_AW'(1);
                            r_state <= ST_WD_HI;
                        end
                    end
                    ST_RA_HI: begin
                        if (w_byte) begin
                            r_hi    <= din_data;
                            r_state <= ST_RA_LO;
                        end
                    end
                    ST_RA_LO: begin
                        if (w_byte) begin
                            if (!run_busy) begin
                                r_run_addr  <= w_word[MEM_AW-1:0];
                                r_run_start <= 1'b1;
                            end
                            r_state <= ST_SKIP;
                        end
                    end
                    ST_SKIP: begin
                        r_state <= ST_SKIP;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)        r_err <= 1'b0;
        else if (w_clr_err) r_err <= 1'b0;
        else if (w_set_err) r_err <= 1'b1;
    end

`ifdef MARLANN_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            r_err_cnt <= '0;
        else if (w_clr_err)
            r_err_cnt <= '0;
        else if (w_set_err && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_count = r_err_cnt;
`endif

    assign mem_wr_valid = w_slot_valid;
    assign mem_wr_addr  = w_slot_addr;
    assign mem_wr_data  = w_slot_data;
    assign run_start    = r_run_start;
    assign run_addr     = r_run_addr;
    assign err          = r_err;
    assign rdy          = !w_slot_valid && !run_busy &&
                          ((r_state == ST_IDLE) || (r_state == ST_SKIP));

endmodule
